// File: rtl/sa_stream_sequencer_pkg.sv
// Shared types for the GEMM tile sequencer: FSM state encoding and pipeline latency helper.
package sa_stream_sequencer_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_STREAM,
    SEQ_DRAIN,
    SEQ_DONE
  } seq_state_t;

  // Skew (SA_SIZE) + array traversal (SA_SIZE) + de-skew register stage.
  function automatic int sa_pipe_lat(input int sa_size);
    return 2 * sa_size + 1;
  endfunction

endpackage

// File: rtl/sa_stream_sequencer_valid_tag_delay.sv
// Unconditional 1-bit shift register carrying row-valid tags alongside the fixed-latency datapath.
module valid_tag_delay #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] tag_sr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_sr <= '0;
    end else begin
      tag_sr <= {tag_sr[DEPTH-2:0], din};
    end
  end

  assign dout = tag_sr[DEPTH-1];

endmodule

// File: rtl/sa_stream_sequencer.sv
// Sequences one GEMM tile through skew -> systolic array -> de-skew; sole flow control for that path.
module sa_stream_sequencer
  import sa_stream_sequencer_pkg::*;
#(
  parameter int SA_SIZE  = 8,
  parameter int LEN_W    = 16,
  parameter int PIPE_LAT = sa_pipe_lat(SA_SIZE)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             act_valid,
  output logic             act_ready,
  output logic             sa_in_sel,
  output logic             sa_acc_clr,
  output logic             out_row_valid,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output seq_state_t       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
  // ready never depends on valid; valid may depend on nothing here.

  seq_state_t       state_q, state_d;
  logic [LEN_W-1:0] len_q, issued_q, retired_q;
  logic             cmd_fire, act_fire, tag_out;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= SEQ_IDLE;
      len_q     <= '0;
      issued_q  <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (cmd_fire) begin
        len_q     <= cmd_len;
        issued_q  <= '0;
        retired_q <= '0;
      end else begin
        if (act_fire)      issued_q  <= issued_q + LEN_W'(1);
        if (out_row_valid) retired_q <= retired_q + LEN_W'(1);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cmd_ready     = 1'b0;
    act_ready     = 1'b0;
    sa_in_sel     = 1'b0;
    sa_acc_clr    = 1'b0;
    cmd_fire      = 1'b0;
    act_fire      = 1'b0;
    out_row_valid = tag_out;
    // Counters are compared before increment so len = 2^LEN_W-1 never wraps.
    out_last      = tag_out && (retired_q == len_q - LEN_W'(1));
    busy          = (state_q != SEQ_IDLE);
    done          = 1'b0;
    unique case (state_q)
      SEQ_IDLE: begin
        cmd_ready = resetn;
        cmd_fire  = cmd_valid && resetn;
        if (cmd_fire) begin
          if (cmd_len != '0) begin
            sa_acc_clr = 1'b1;
            state_d    = SEQ_STREAM;
          end else begin
            state_d = SEQ_DONE;
          end
        end
      end
      SEQ_STREAM: begin
        act_ready = 1'b1;
        act_fire  = act_valid;
        sa_in_sel = act_valid;
        if (act_fire && (issued_q == len_q - LEN_W'(1))) state_d = SEQ_DRAIN;
      end
      SEQ_DRAIN: begin
        if (out_last) state_d = SEQ_DONE;
      end
      SEQ_DONE: begin
        done    = 1'b1;
        state_d = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  // A bubble pushes a 0 tag, so output spacing mirrors input spacing.
  valid_tag_delay #(.DEPTH(PIPE_LAT)) u_tag_delay (
    .clk    (clk),
    .resetn (resetn),
    .din    (act_fire),
    .dout   (tag_out)
  );

  assign state_dbg = state_q;

endmodule

// File: tb/tb_sa_stream_sequencer.sv
// Self-checking bench for sa_stream_sequencer: vector table, hand sequences and randomized tiles.
module tb_sa_stream_sequencer;
  import sa_stream_sequencer_pkg::*;

  localparam int SA_SIZE  = 4;
  localparam int LEN_W    = 16;
  localparam int PIPE_LAT = 9;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             act_valid = 1'b0;
  logic             cmd_ready, act_ready, sa_in_sel, sa_acc_clr;
  logic             out_row_valid, out_last, busy, done;
  seq_state_t       state_dbg;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    int          len;
    logic [15:0] pat;
    int          exp_done;
    logic [31:0] exp_mask;
    int          exp_clr;
  } vec_t;
  vec_t vecs[7];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  sa_stream_sequencer #(.SA_SIZE(SA_SIZE), .LEN_W(LEN_W)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_len       (cmd_len),
    .act_valid     (act_valid),
    .act_ready     (act_ready),
    .sa_in_sel     (sa_in_sel),
    .sa_acc_clr    (sa_acc_clr),
    .out_row_valid (out_row_valid),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done),
    .state_dbg     (state_dbg)
  );

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".cmd_ready"},     cmd_ready,     0);
    check({tag, ".act_ready"},     act_ready,     0);
    check({tag, ".sa_in_sel"},     sa_in_sel,     0);
    check({tag, ".sa_acc_clr"},    sa_acc_clr,    0);
    check({tag, ".out_row_valid"}, out_row_valid, 0);
    check({tag, ".out_last"},      out_last,      0);
    check({tag, ".busy"},          busy,          0);
    check({tag, ".done"},          done,          0);
  endtask

  // ---------------- driver + reference model ----------------
  // Called just after a rising edge with the DUT idle. Cycle k=0 presents the command;
  // act_valid for stream cycles comes from pat (LSB first, 1 beyond bit 15) or random.
  // Expected behaviour: handshakes are the first len cycles k>=1 with act_valid=1; each row
  // appears PIPE_LAT cycles after its handshake; done follows the last row by one cycle.
  task automatic run_tile(input int len, input logic [15:0] pat, input bit rnd,
                          output int done_k, output logic [31:0] out_mask, output int clr_cnt);
    bit av[256];
    int n = 0;
    int h_last = 0;
    int e_done;
    bit exp_o;
    for (int k = 1; n < len && k < 250; k++) begin
      if (rnd) av[k] = ($urandom_range(0, 3) != 0);
      else     av[k] = (k - 1 < 16) ? pat[k-1] : 1'b1;
      if (av[k]) begin
        n++;
        h_last = k;
        exp_q.push_back(32'(k + PIPE_LAT));
      end
    end
    e_done   = (len > 0) ? h_last + PIPE_LAT + 1 : 1;
    done_k   = -1;
    out_mask = '0;
    clr_cnt  = 0;
    for (int k = 0; k <= e_done + 1; k++) begin
      cmd_valid = (k == 0);
      if (k == 0) cmd_len = LEN_W'(len);
      act_valid = (k >= 1 && k <= h_last) ? av[k] : 1'($urandom_range(0, 1));
      @(negedge clk);
      check("cmd_ready",  cmd_ready,  32'(k == 0 || k == e_done + 1));
      check("sa_acc_clr", sa_acc_clr, 32'(k == 0 && len > 0));
      check("act_ready",  act_ready,  32'(k >= 1 && k <= h_last));
      check("sa_in_sel",  sa_in_sel,  32'(k >= 1 && k <= h_last && act_valid));
      check("out_last",   out_last,   32'(len > 0 && k == h_last + PIPE_LAT));
      check("done",       done,       32'(k == e_done));
      check("busy",       busy,       32'(k >= 1 && k <= e_done));
      exp_o = (exp_q.size() > 0) && (exp_q[0] == 32'(k));
      check("out_row_valid", out_row_valid, 32'(exp_o));
      if (exp_o) void'(exp_q.pop_front());
      if (done && done_k < 0) done_k = k;
      if (out_row_valid && k >= PIPE_LAT + 1 && k - PIPE_LAT - 1 < 32) out_mask[k-PIPE_LAT-1] = 1'b1;
      if (sa_acc_clr) clr_cnt++;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    check("exp_q_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d_k, c_n;
    logic [31:0] m;

    vecs[0] = '{len: 5, pat: 16'hFFFF, exp_done: 15, exp_mask: 32'h1F,  exp_clr: 1};
    vecs[1] = '{len: 3, pat: 16'h0019, exp_done: 15, exp_mask: 32'h19,  exp_clr: 1};
    vecs[2] = '{len: 0, pat: 16'hFFFF, exp_done: 1,  exp_mask: 32'h0,   exp_clr: 0};
    vecs[3] = '{len: 1, pat: 16'h0002, exp_done: 12, exp_mask: 32'h2,   exp_clr: 1};
    vecs[4] = '{len: 2, pat: 16'h0005, exp_done: 13, exp_mask: 32'h5,   exp_clr: 1};
    vecs[5] = '{len: 8, pat: 16'hFFFF, exp_done: 18, exp_mask: 32'hFF,  exp_clr: 1};
    vecs[6] = '{len: 4, pat: 16'h00F0, exp_done: 18, exp_mask: 32'hF0,  exp_clr: 1};

    // 1. reset
    resetn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_all_zero("in_reset");
      @(posedge clk);
    end
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check("post_reset.cmd_ready", cmd_ready, 1);
    check("post_reset.busy",      busy,      0);
    check("post_reset.done",      done,      0);
    check("post_reset.out_valid", out_row_valid, 0);
    check("post_reset.state",     state_dbg, SEQ_IDLE);
    @(posedge clk);
    #1;

    // 2-4. vector table
    for (int i = 0; i < 7; i++) begin
      run_tile(vecs[i].len, vecs[i].pat, 1'b0, d_k, m, c_n);
      check($sformatf("vec%0d.done_cycle", i), d_k, vecs[i].exp_done);
      check($sformatf("vec%0d.out_mask", i),   m,   vecs[i].exp_mask);
      check($sformatf("vec%0d.clr_count", i),  c_n, vecs[i].exp_clr);
    end

    // 5. back-to-back commands with cmd_valid held: lens 2 then 1
    for (int k = 0; k <= 26; k++) begin
      cmd_valid = (k <= 13);
      cmd_len   = (k <= 12) ? LEN_W'(2) : LEN_W'(1);
      act_valid = 1'b1;
      @(negedge clk);
      check("b2b.cmd_ready",     cmd_ready,     32'(k == 0 || k == 13 || k >= 25));
      check("b2b.sa_acc_clr",    sa_acc_clr,    32'(k == 0 || k == 13));
      check("b2b.act_ready",     act_ready,     32'(k == 1 || k == 2 || k == 14));
      check("b2b.out_row_valid", out_row_valid, 32'(k == 10 || k == 11 || k == 23));
      check("b2b.out_last",      out_last,      32'(k == 11 || k == 23));
      check("b2b.done",          done,          32'(k == 12 || k == 24));
      check("b2b.busy",          busy,          32'((k >= 1 && k <= 12) || (k >= 14 && k <= 24)));
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    act_valid = 1'b0;

    // 6. abort after 3 rows with an asynchronous mid-cycle reset
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(6);
    act_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort.busy_before", busy, 1);
    #2;
    resetn = 1'b0;
    #1;
    check_all_zero("abort_async");
    check("abort.state", state_dbg, SEQ_IDLE);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("abort.out_row_valid", out_row_valid, 0);
      check("abort.done",          done,          0);
      check("abort.busy",          busy,          0);
      @(posedge clk);
      #1;
    end
    act_valid = 1'b0;
    run_tile(1, 16'hFFFF, 1'b0, d_k, m, c_n);
    check("after_abort.done_cycle", d_k, 11);
    check("after_abort.out_mask",   m,   32'h1);

    // randomized tiles against the reference model
    for (int t = 0; t < 20; t++) begin
      run_tile(int'($urandom_range(0, 12)), 16'h0, 1'b1, d_k, m, c_n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
